// File: rtl/matrix_operand_loader_pkg.sv
// Shared types and address-map helpers for matrix_operand_loader.
// The address width and the control-register offsets are all functions of the matrix dimension N.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_t;

    function automatic int operand_words(input int n);
        return 4 * n * n;
    endfunction

    function automatic int loader_aw(input int n);
        return $clog2(4 * n * n + 3);
    endfunction

    function automatic int start_addr(input int n);
        return 4 * n * n;
    endfunction

    function automatic int clear_addr(input int n);
        return 4 * n * n + 1;
    endfunction

    function automatic int stream_addr(input int n);
        return 4 * n * n + 2;
    endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Write bus, multiplier handshake and operand outputs of matrix_operand_loader.
// The readback port pair exists only when LOADER_READBACK_EN is defined.
interface matrix_operand_loader_if #(
    parameter int N = 4,
    parameter int W = 32
) ();
    import matrix_loader_pkg::*;

    localparam int AW = loader_aw(N);

    logic [W-1:0]         InDatos;
    logic                 Write;
    logic [AW-1:0]        Address;
    logic                 MulDone;
    logic [2*N*N*W-1:0]   AFlat;
    logic [2*N*N*W-1:0]   BFlat;
    logic                 Start;
    logic                 Loaded;
    logic                 Busy;
    logic                 WriteError;
`ifdef LOADER_READBACK_EN
    logic [AW-1:0]        RdAddress;
    logic [W-1:0]         RdData;
`endif

    modport master (
        output InDatos, Write, Address, MulDone,
`ifdef LOADER_READBACK_EN
        output RdAddress,
        input  RdData,
`endif
        input  AFlat, BFlat, Start, Loaded, Busy, WriteError
    );

    modport slave (
        input  InDatos, Write, Address, MulDone,
`ifdef LOADER_READBACK_EN
        input  RdAddress,
        output RdData,
`endif
        output AFlat, BFlat, Start, Loaded, Busy, WriteError
    );

endinterface

// File: rtl/matrix_operand_loader_operand_word_reg.sv
// One operand word: W-bit enabled register plus a valid flag set on write and dropped by clear.
// The clear only drops the flag; the stored data is retained.
module operand_word_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // NOTE: every state element here is a flop with a synchronous reset, so the
    // whole operand store returns to zero on reset rather than keeping stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            if (en) begin
                q     <= d;
                valid <= 1'b1;
            end else if (clr) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Operand store and launch controller feeding a complex N x N matrix multiplier.
// Optional readback port enabled by defining LOADER_READBACK_EN.
module matrix_operand_loader
    import matrix_loader_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = 8
) (
    input  logic                    CLK,
    input  logic                    MasterReset,
    matrix_operand_loader_if.slave  bus
);

    localparam int AW    = loader_aw(N);
    localparam int TOTAL = operand_words(N);
    localparam int HALF  = TOTAL / 2;

    localparam logic [AW-1:0] ADDR_START  = AW'(start_addr(N));
    localparam logic [AW-1:0] ADDR_CLEAR  = AW'(clear_addr(N));
    localparam logic [AW-1:0] ADDR_STREAM = AW'(stream_addr(N));
    localparam logic [AW-1:0] COUNT_FULL  = AW'(TOTAL);
    localparam logic [AW-1:0] PTR_LAST    = AW'(TOTAL - 1);

    state_t          state;
    logic [AW-1:0]   count;
    logic [AW-1:0]   ptr;
    logic            start_q;
    logic            loaded_q;
    logic            busy_q;
    logic            werr_q;

    logic [W-1:0]    words [TOTAL];
    logic [TOTAL-1:0] valid;
    logic [TOTAL-1:0] word_en;
    logic            clear_all;

    logic            is_operand;
    logic            is_stream;
    logic            is_clear;
    logic            is_start;
    logic            is_bad;
    logic            accept;
    logic [AW-1:0]   target;
    logic            target_valid;
    logic [AW-1:0]   count_inc;

    logic signed [IW-1:0] narrow;
    logic [W-1:0]         operand_value;

    // Only the low IW bits are stored; the upper input bits are don't-care.
    logic unused_indatos;
    assign unused_indatos = ^bus.InDatos;

    assign narrow        = bus.InDatos[IW-1:0];
    assign operand_value = W'(narrow);

    // NOTE: always_comb gives every output a default before any conditional
    // assignment, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        is_operand   = bus.Address < ADDR_START;
        is_stream    = bus.Address == ADDR_STREAM;
        is_clear     = bus.Address == ADDR_CLEAR;
        is_start     = bus.Address == ADDR_START;
        is_bad       = bus.Address > ADDR_STREAM;
        accept       = bus.Write && (state != RUN);
        target       = is_stream ? ptr : bus.Address;
        target_valid = 1'b0;
        word_en      = '0;
        for (int k = 0; k < TOTAL; k++) begin
            if (target == AW'(k)) begin
                target_valid = valid[k];
                word_en[k]   = accept && (is_operand || is_stream);
            end
        end
        clear_all = accept && is_clear;
        count_inc = target_valid ? count : count + AW'(1);
    end

    for (genvar k = 0; k < TOTAL; k++) begin : g_word
        operand_word_reg #(.W(W)) u_word (
            .clk   (CLK),
            .rst_n (MasterReset),
            .en    (word_en[k]),
            .clr   (clear_all),
            .d     (operand_value),
            .q     (words[k]),
            .valid (valid[k])
        );
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!MasterReset) begin
            state    <= IDLE;
            count    <= '0;
            ptr      <= '0;
            start_q  <= 1'b0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            werr_q  <= 1'b0;
            if (state == RUN) begin
                // Operands are frozen while the multiplier reads them.
                if (bus.Write) werr_q <= 1'b1;
                if (bus.MulDone) begin
                    state  <= READY;
                    busy_q <= 1'b0;
                end
            end else if (bus.Write) begin
                if (is_bad) begin
                    werr_q <= 1'b1;
                end else if (is_operand || is_stream) begin
                    count    <= count_inc;
                    loaded_q <= (count_inc == COUNT_FULL);
                    state    <= (count_inc == COUNT_FULL) ? READY : FILL;
                    if (is_stream) ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
                end else if (is_clear) begin
                    count    <= '0;
                    ptr      <= '0;
                    loaded_q <= 1'b0;
                    state    <= IDLE;
                end else if (is_start && bus.InDatos[0]) begin
                    if (state == READY) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end else begin
                        werr_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic [HALF*W-1:0] a_flat;
    logic [HALF*W-1:0] b_flat;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int k = 0; k < HALF; k++) begin
            a_flat[k*W +: W] = words[k];
            b_flat[k*W +: W] = words[HALF + k];
        end
    end

    assign bus.AFlat      = a_flat;
    assign bus.BFlat      = b_flat;
    assign bus.Start      = start_q;
    assign bus.Loaded     = loaded_q;
    assign bus.Busy       = busy_q;
    assign bus.WriteError = werr_q;

`ifdef LOADER_READBACK_EN
    logic [W-1:0] rd_data;

    always_ff @(posedge CLK) begin
        if (!MasterReset) begin
            rd_data <= '0;
        end else begin
            rd_data <= '0;
            for (int k = 0; k < TOTAL; k++) begin
                if (bus.RdAddress == AW'(k)) rd_data <= words[k];
            end
            if (bus.RdAddress == ADDR_START) rd_data <= W'(count);
        end
    end

    assign bus.RdData = rd_data;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: a driver updates a word-array model and queues
// the expected outputs; an independent monitor compares them one cycle after each edge.
module tb_matrix_operand_loader;
    import matrix_loader_pkg::*;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int IW    = 8;
    localparam int TOTAL = 4 * N * N;
    localparam int HALF  = 2 * N * N;
    localparam int AW    = loader_aw(N);
    localparam int FW    = HALF * W;
    localparam int A_START  = TOTAL;
    localparam int A_CLEAR  = TOTAL + 1;
    localparam int A_STREAM = TOTAL + 2;

    typedef struct {
        logic          start;
        logic          loaded;
        logic          busy;
        logic          werr;
        logic [FW-1:0] a;
        logic [FW-1:0] b;
    } exp_t;

    logic CLK = 1'b0;
    logic MasterReset;
    always #5 CLK = ~CLK;

    matrix_operand_loader_if #(.N(N), .W(W)) bus ();

    matrix_operand_loader #(.N(N), .W(W), .IW(IW)) dut (
        .CLK         (CLK),
        .MasterReset (MasterReset),
        .bus         (bus)
    );

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference state: plain word/valid arrays, a stream pointer and a running flag.
    logic [W-1:0] m_words [TOTAL];
    bit           m_valid [TOTAL];
    int           m_ptr;
    bit           m_run;

    task automatic model_reset();
        for (int k = 0; k < TOTAL; k++) begin
            m_words[k] = '0;
            m_valid[k] = 1'b0;
        end
        m_ptr = 0;
        m_run = 1'b0;
    endtask

    function automatic bit all_valid();
        int n = 0;
        for (int k = 0; k < TOTAL; k++) n += m_valid[k];
        return n == TOTAL;
    endfunction

    // One clock of stimulus: drive at the falling edge, advance the model, queue the expectation.
    task automatic step(input bit w, input int a, input logic [W-1:0] d, input bit md, input bit rst);
        exp_t e;
        @(negedge CLK);
        MasterReset     = !rst;
        bus.Write       = w;
        bus.Address     = AW'(a);
        bus.InDatos     = d;
        bus.MulDone     = md;
        e.start = 1'b0;
        e.werr  = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_run) begin
            if (w) e.werr = 1'b1;
            if (md) m_run = 1'b0;
        end else if (w) begin
            if (a > A_STREAM) begin
                e.werr = 1'b1;
            end else if (a < A_START || a == A_STREAM) begin
                int idx = (a == A_STREAM) ? m_ptr : a;
                m_words[idx] = {{(W-IW){d[IW-1]}}, d[IW-1:0]};
                m_valid[idx] = 1'b1;
                if (a == A_STREAM) m_ptr = (m_ptr + 1) % TOTAL;
            end else if (a == A_CLEAR) begin
                for (int k = 0; k < TOTAL; k++) m_valid[k] = 1'b0;
                m_ptr = 0;
            end else if (d[0]) begin
                if (all_valid()) begin
                    m_run   = 1'b1;
                    e.start = 1'b1;
                end else begin
                    e.werr = 1'b1;
                end
            end
        end
        e.loaded = all_valid();
        e.busy   = m_run;
        for (int k = 0; k < HALF; k++) begin
            e.a[k*W +: W] = m_words[k];
            e.b[k*W +: W] = m_words[HALF + k];
        end
        q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per edge, sampled 1ns after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("Start",      FW'(bus.Start),      FW'(e.start));
                check("Loaded",     FW'(bus.Loaded),     FW'(e.loaded));
                check("Busy",       FW'(bus.Busy),       FW'(e.busy));
                check("WriteError", FW'(bus.WriteError), FW'(e.werr));
                check("AFlat",      bus.AFlat,           e.a);
                check("BFlat",      bus.BFlat,           e.b);
            end
        end
    end

    initial begin
        MasterReset = 1'b0;
        bus.Write   = 1'b0;
        bus.Address = '0;
        bus.InDatos = '0;
        bus.MulDone = 1'b0;
`ifdef LOADER_READBACK_EN
        bus.RdAddress = '0;
`endif
        model_reset();

        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);

        // Negative byte is sign-extended into word 0.
        step(1, 0, 32'h80, 0, 0);
        idle();

        // Stream fill 1..64, then one more stream write lands on word 0.
        step(1, A_CLEAR, '0, 0, 0);
        for (int v = 1; v <= TOTAL; v++) step(1, A_STREAM, 32'(v), 0, 0);
        idle();
        step(1, A_STREAM, 32'h7F, 0, 0);

        // Launch, then a rejected write while running.
        step(1, A_START, 32'h1, 0, 0);
        step(1, 5, 32'h55, 0, 0);
        idle();
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        step(1, A_START, 32'h2, 0, 0);

        // CLEAR in RUN rejected; MulDone with a write returns to READY with the write rejected.
        step(1, A_START, 32'h1, 0, 0);
        step(1, A_CLEAR, '0, 0, 0);
        step(1, 7, 32'h12, 1, 0);
        step(1, A_CLEAR, '0, 0, 0);
        idle();

        // Early START in IDLE and FILL, then out-of-map addresses.
        step(1, A_START, 32'h1, 0, 0);
        step(1, 3, 32'hF0, 0, 0);
        step(1, A_START, 32'h1, 0, 0);
        step(1, A_START, 32'h1, 0, 0);
        step(1, TOTAL + 3, 32'h9, 0, 0);
        step(1, (1 << AW) - 1, 32'h9, 0, 0);
        idle();

        for (int i = 0; i < 800; i++) begin
            int sel = $urandom_range(0, 9);
            int a;
            bit w   = $urandom_range(0, 99) < 75;
            bit md  = $urandom_range(0, 9) == 0;
            bit rst = $urandom_range(0, 299) == 0;
            if (sel < 5)       a = A_STREAM;
            else if (sel < 8)  a = $urandom_range(0, TOTAL - 1);
            else if (sel == 8) a = A_START;
            else               a = $urandom_range(TOTAL + 1, (1 << AW) - 1);
            step(w, a, $urandom, md, rst);
        end

        // Reset in the middle of a run.
        step(1, A_CLEAR, '0, 0, 0);
        for (int v = 0; v < TOTAL; v++) step(1, A_STREAM, $urandom, 0, 0);
        step(1, A_START, 32'h1, 0, 0);
        idle();
        step(0, 0, '0, 0, 1);
        idle();
        idle();

        // Reset in the middle of a stream.
        for (int v = 0; v < 5; v++) step(1, A_STREAM, $urandom, 0, 0);
        step(1, A_STREAM, 32'h3, 0, 1);
        step(1, A_STREAM, 32'h44, 0, 0);
        idle();
        idle();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
        #2;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
